// File: rtl/fetch_controller.sv
// fetch_controller: owns the byte PC, drives a combinational instruction memory
// and hands fetched words to decode through a 2-entry {pc, instr} buffer.
// Handles branch redirects, halt/drain and fetch faults (misaligned or out of range).
module fetch_controller #(
  parameter logic [63:0] PC_RESET   = 64'h0,
  parameter int          IMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        halt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  output logic        fetch_fault,
  output logic [63:0] pc
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [61:0] WORDS = 62'(IMEM_WORDS);

  state_t      state;
  logic [1:0]  count;
  logic [63:0] tail_pc;
  logic [31:0] tail_instr;

  logic pop;
  logic room;
  logic issue;
  logic fetch;
  logic overrun;
  logic pc_in_range;
  logic target_ok;

  assign imem_addr   = {2'b00, pc[63:2]};
  assign out_valid   = (count != 2'd0);
  assign pop         = out_valid & out_ready;
  assign pc_in_range = (pc[63:2] < WORDS);
  assign target_ok   = (redirect_pc[1:0] == 2'b00) && (redirect_pc[63:2] < WORDS);
  // A slot is available if the buffer is not full or the head leaves this cycle.
  assign room        = (count != 2'd2) | pop;
  // HALT with halt released behaves like RUN so fetch resumes the same cycle.
  assign issue       = (state != FAULT) & ~halt & ~redirect_valid & room;
  assign fetch       = issue & pc_in_range;
  assign overrun     = issue & ~pc_in_range;

  // Control FSM: PC sequencing, redirect handling and the registered fault flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      pc          <= PC_RESET;
      fetch_fault <= 1'b0;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
      if (!target_ok) begin
        state       <= FAULT;
        fetch_fault <= 1'b1;
      end else begin
        state       <= halt ? HALT : RUN;
        fetch_fault <= 1'b0;
      end
    end else if (state != FAULT) begin
      if (halt) begin
        state <= HALT;
      end else if (overrun) begin
        state       <= FAULT;
        fetch_fault <= 1'b1;
      end else begin
        state <= RUN;
        if (fetch) pc <= pc + 64'd4;
      end
    end
  end

  // Two-entry buffer: the head registers drive out_* directly, tail holds the second word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= 2'd0;
      out_pc     <= 64'd0;
      out_instr  <= 32'd0;
      tail_pc    <= 64'd0;
      tail_instr <= 32'd0;
    end else if (redirect_valid) begin
      count <= 2'd0;
    end else begin
      case ({fetch, pop})
        2'b11: begin
          if (count == 2'd2) begin
            out_pc     <= tail_pc;
            out_instr  <= tail_instr;
            tail_pc    <= pc;
            tail_instr <= imem_instr;
          end else begin
            out_pc    <= pc;
            out_instr <= imem_instr;
          end
        end
        2'b10: begin
          if (count == 2'd0) begin
            out_pc    <= pc;
            out_instr <= imem_instr;
          end else begin
            tail_pc    <= pc;
            tail_instr <= imem_instr;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          out_pc    <= tail_pc;
          out_instr <= tail_instr;
          count     <= count - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequences the combinational instruction memory (word-indexed, 1024 x 32) for the core's fetch stage.
- Owns the byte-granular PC and drives the word address to the memory each cycle.
- Captures returned words with their PC into a 2-entry buffer that decode drains over a valid/ready handshake.
- Handles branch redirects, halt/drain and fetch faults (misaligned or out-of-range PC).

Parameters:
- PC_RESET, 64'h0, byte PC loaded on reset; must be 4-byte aligned.
- IMEM_WORDS, 1024, number of instruction words; a PC is in range iff pc[63:2] < IMEM_WORDS.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- imem_addr  output  64  word index to instruction memory; combinational, always equal to {2'b00, pc[63:2]}.
- imem_instr  input  32  instruction word returned combinationally for imem_addr.
- redirect_valid  input  1  branch/jump redirect request.
- redirect_pc  input  64  byte target of the redirect.
- halt  input  1  level; stop issuing new fetches while high.
- out_valid  output  1  buffer head holds a valid instruction.
- out_ready  input  1  decode accepts the head this cycle.
- out_instr  output  32  instruction at the buffer head.
- out_pc  output  64  byte PC of out_instr.
- fetch_fault  output  1  high while in FAULT state.
- pc  output  64  current fetch PC (debug/branch unit).

Behaviour:
- Reset (async, immediate): pc=PC_RESET, buffer count=0, state=RUN, out_valid=0, out_instr=0, out_pc=0, fetch_fault=0.
- Buffer: 2-entry FIFO of {pc, instr}.
  - Head drives out_pc/out_instr directly from registers; undefined-value-free: entries cleared to 0 on reset only.
  - out_valid = (count != 0).
- pop = out_valid & out_ready.
- fetch condition:
  - state==RUN & !halt & !redirect_valid & pc in range & (count<2 | pop).
  - On fetch: enqueue {pc, imem_instr}; pc <= pc+4 (64-bit wrap, unreachable in range).
  - Latency: word at address A is visible at out_* the cycle after A is on imem_addr (1 cycle).
  - Throughput: 1 instr/cycle with out_ready held high.
- Simultaneous fetch and pop: count unchanged, head advances, new entry written to the freed tail.
- Full (count==2) & !pop: no fetch, pc holds, imem_addr holds.
- Redirect (highest priority, any state):
  - A pop in the same cycle is still a completed transfer of the old head.
  - Buffer flushed (count<=0); no enqueue that cycle.
  - If redirect_pc[1:0]==0 and in range: pc<=redirect_pc, state<=RUN (or HALT if halt high). Otherwise pc<=redirect_pc, state<=FAULT.
  - First redirected instruction appears at out_* 2 cycles after the redirect cycle.
- State machine:
  - RUN -> HALT when halt=1 (no fetch that cycle); existing entries still drain.
  - HALT -> RUN when halt=0; fetch resumes the same cycle at held pc.
  - RUN -> FAULT when the fetch condition is otherwise met but pc is out of range (sequential overrun past the last word); no enqueue, pc holds.
  - FAULT: no fetch; buffered entries still drain; exited only by a valid redirect or reset.
- fetch_fault is registered: high the cycle after entering FAULT, low the cycle after leaving.
- Empty: out_valid=0; out_ready ignored.
- Reset mid-operation: all state dropped immediately; no partial entries survive.

Test Plan:
- Reset then run with out_ready=1, memory word i = 32'h1000_0000+i -> out_valid rises the cycle after reset release. out_pc=0,4,8,… with out_instr=32'h1000_0000,…0001,…0002 on consecutive cycles; imem_addr=0,1,2.
- Backpressure: out_ready=0 from cycle 3 -> count saturates at 2 and pc stops. On out_ready=1, entries drain in order with no loss or duplicate; fetch resumes the same cycle as the first pop.
- Redirect at pc=0x10 with redirect_pc=0x40 and a pop in the same cycle:
  - The popped entry counts as transferred.
  - Buffer flushes.
  - The next out_pc is 0x40, 2 cycles later, with instr 32'h1000_0010.
- Misaligned redirect_pc=0x42 -> fetch_fault=1 next cycle and no further fetch. A later redirect to 0x8 clears fetch_fault and out_pc=0x8 appears.
- Sequential run to pc=0xFFC (word 1023) -> word 1023 is delivered. At pc=0x1000 the block enters FAULT, the buffer drains, and out_valid then stays 0.
- halt=1 for 5 cycles with 1 entry buffered -> the entry drains and no new fetch occurs. halt=0 resumes at the held pc; assert reset mid-halt -> out_valid=0 and pc=0 immediately.
